// File: rtl/tns_decoder_21.sv
// Iterative TNS 21-bit codeword decoder: one 3-bit group per cycle, MSB group first.
// Optional TNS_CHECK_EN adds an overflow/illegal-group error flag on err.

`ifndef BLEN07
`define BLEN07 19
`endif

// Fallback weights: group g digit is a 3-bit binary value scaled by 7^(g-1).
`ifndef TNS01_A
`define TNS01_A 4
`define TNS01_B 2
`define TNS01_C 1
`define TNS02_A 28
`define TNS02_B 14
`define TNS02_C 7
`define TNS03_A 196
`define TNS03_B 98
`define TNS03_C 49
`define TNS04_A 1372
`define TNS04_B 686
`define TNS04_C 343
`define TNS05_A 9604
`define TNS05_B 4802
`define TNS05_C 2401
`define TNS06_A 67228
`define TNS06_B 33614
`define TNS06_C 16807
`define TNS07_A 470596
`define TNS07_B 235298
`define TNS07_C 117649
`endif

module tns_decoder_21 (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [20:0]        codein,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [`BLEN07-1:0] dataout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err
);

  localparam int unsigned DataW = `BLEN07;
`ifdef TNS_CHECK_EN
  localparam int unsigned AccW = DataW + 1;
`else
  localparam int unsigned AccW = DataW;
`endif

  // Indexed by group counter (group number minus one); entry 7 is never used.
  localparam int unsigned WeightA [8] = '{`TNS01_A, `TNS02_A, `TNS03_A, `TNS04_A,
                                          `TNS05_A, `TNS06_A, `TNS07_A, 0};
  localparam int unsigned WeightB [8] = '{`TNS01_B, `TNS02_B, `TNS03_B, `TNS04_B,
                                          `TNS05_B, `TNS06_B, `TNS07_B, 0};
  localparam int unsigned WeightC [8] = '{1, `TNS02_C, `TNS03_C, `TNS04_C,
                                          `TNS05_C, `TNS06_C, `TNS07_C, 0};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [20:0]        code_q;
  logic [2:0]         grp_q;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [DataW-1:0]   data_q;
  logic [2:0]         grp_bits;
  logic               accept;
  int unsigned        term;

  assign accept   = (state_q == StIdle) && in_valid;
  assign grp_bits = code_q[20:18];
  assign dataout  = data_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StBusy;
      StBusy:  if (grp_q == 3'd0) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    term = 0;
    if (grp_bits[2]) term = term + WeightA[grp_q];
    if (grp_bits[1]) term = term + WeightB[grp_q];
    if (grp_bits[0]) term = term + WeightC[grp_q];
    acc_d = acc_q + AccW'(term);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      grp_q  <= '0;
      acc_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      code_q <= codein;
      grp_q  <= 3'd6;
      acc_q  <= '0;
    end else if (state_q == StBusy) begin
      // Shift the next group into the top three bits.
      code_q <= {code_q[17:0], 3'b000};
      grp_q  <= grp_q - 3'd1;
      acc_q  <= acc_d;
      if (grp_q == 3'd0) data_q <= acc_d[DataW-1:0];
    end
  end

`ifdef TNS_CHECK_EN
  logic flag_q, flag_d, err_q;

  // A group of 111 is never produced by the encoder.
  assign flag_d = flag_q | (&grp_bits);
  assign err    = err_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      flag_q <= 1'b0;
    end else if (state_q == StBusy) begin
      flag_q <= flag_d;
      if (grp_q == 3'd0) err_q <= acc_d[AccW-1] | flag_d;
    end else if ((state_q == StDone) && out_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tns_decoder_21.sv
// Self-checking bench for tns_decoder_21: digit-level reference model plus per-cycle compare.
// Honours TNS_CHECK_EN when defined for the build.

`ifndef BLEN07
`define BLEN07 19
`endif

module tb_tns_decoder_21;

  localparam int     DataW = `BLEN07;
  localparam longint Lim   = longint'(1) << DataW;
`ifdef TNS_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic [20:0]      codein = '0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic             in_ready, out_valid, err;
  logic [DataW-1:0] dataout;

  int     n_checks = 0;
  int     n_errors = 0;
  int     m_phase;
  longint m_data;
  bit     m_err;

  always #5 clock = ~clock;

  tns_decoder_21 dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .codein    (codein),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  // Weighted sum: group g (0-based) carries a 3-bit digit scaled by 7^g.
  function automatic longint model_sum(input logic [20:0] w);
    longint s = 0;
    longint p = 1;
    for (int g = 0; g < 7; g++) begin
      for (int k = 0; k < 3; k++)
        if (w[3*g+k]) s += (g == 0 && k == 0) ? 1 : (longint'(1) << k) * p;
      p = p * 7;
    end
    return s;
  endfunction

  function automatic longint model_data(input logic [20:0] w);
    return model_sum(w) % Lim;
  endfunction

  function automatic bit model_err(input logic [20:0] w);
    bit e = 1'b0;
    if (!ChkEn) return 1'b0;
    if (model_sum(w) >= Lim) e = 1'b1;
    for (int g = 0; g < 7; g++) if (w[3*g +: 3] == 3'b111) e = 1'b1;
    return e;
  endfunction

  function automatic logic [20:0] encode(input longint v);
    logic [20:0] c = '0;
    longint r = v;
    for (int g = 0; g < 7; g++) begin
      c[3*g +: 3] = 3'(r % 7);
      r = r / 7;
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Phase -1 idle, 0..6 busy, 7 result pending.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= -1;
    end else if (m_phase == -1) begin
      if (in_valid) begin
        m_phase <= 0;
        m_data  <= model_data(codein);
        m_err   <= model_err(codein);
      end
    end else if (m_phase < 7) begin
      m_phase <= m_phase + 1;
    end else if (out_ready) begin
      m_phase <= -1;
    end
  end

  always @(negedge clock) begin
    if (rst_n) begin
      chk("cyc_in_ready", in_ready, m_phase == -1);
      chk("cyc_out_valid", out_valid, m_phase == 7);
      if (m_phase == 7) begin
        chk("cyc_dataout", dataout, m_data);
        chk("cyc_err", err, m_err);
      end
    end
  end

  // Must be called just after a rising edge.
  task automatic send(input logic [20:0] w);
    codein   = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    timeout("send");
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) return;
      chk("busy_in_ready", in_ready, 0);
      @(posedge clock);
      #1;
      n++;
    end
    timeout("wait_valid");
  endtask

  task automatic run_lit(input logic [20:0] w, input longint want, input bit want_err);
    int n;
    send(w);
    wait_valid(n);
    chk($sformatf("latency_%06h", w), n + 1, 8);
    chk($sformatf("lit_data_%06h", w), dataout, want);
    chk($sformatf("lit_err_%06h", w), err, want_err);
    @(posedge clock);
    #1;
    chk("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    int n;
    bit got;
    longint v;
    logic [20:0] w1, w2;
    logic [DataW-1:0] d0;

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_err", err, 0);
    @(negedge clock);
    #2 rst_n = 1'b1;
    @(posedge clock);
    #1;

    run_lit(21'h000000, 0, 1'b0);
    run_lit(21'h000001, 1, 1'b0);
    run_lit(21'h100000, 470596, 1'b0);
    run_lit(21'h000002, 2, 1'b0);
    run_lit(21'h000008, 7, 1'b0);
    run_lit(encode(12345), 12345, 1'b0);
    run_lit(21'h1FFFFF, 436511, ChkEn);

    // Asynchronous abort mid-BUSY.
    send(21'h0ABCDE);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_dataout", dataout, 0);
    chk("abort_err", err, 0);
    @(negedge clock);
    #2 rst_n = 1'b1;
    repeat (15) begin
      @(negedge clock);
      chk("abort_no_pulse", out_valid, 0);
    end
    @(posedge clock);
    #1;

    // Backpressure with a second word waiting.
    w1 = encode(98765);
    w2 = encode(4321);
    out_ready = 1'b0;
    send(w1);
    codein   = w2;
    in_valid = 1'b1;
    wait_valid(n);
    d0 = dataout;
    chk("bp_first_data", d0, 98765);
    repeat (20) begin
      @(negedge clock);
      chk("bp_stable", dataout, d0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    @(posedge clock);
    #1;
    chk("bp_second_taken", in_ready, 0);
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_second_data", dataout, 4321);
    @(posedge clock);
    #1;

    // Round trip through the reference encoder with random stalls.
    for (int i = 0; i < 1000; i++) begin
      v = longint'($urandom) % Lim;
      if (i == 0) v = 0;
      if (i == 1) v = Lim - 1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      send(encode(v));
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clock);
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          chk("roundtrip", dataout, v);
          got = 1'b1;
          break;
        end
      end
      if (!got) timeout("roundtrip");
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;

    // Arbitrary codewords, including illegal groups, against the model.
    for (int i = 0; i < 200; i++) begin
      send(21'($urandom));
      wait_valid(n);
      @(posedge clock);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
